// File: rtl/im_access_controller.sv
// Single-port instruction memory arbiter: serves fetch reads and sequences
// burst program loads, stalling fetch while a load owns the port.
module im_access_controller #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              stall,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_count,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0]   fetch_instr_q, fetch_instr_d;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        rem_d         = rem_q;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        mem_we        = 1'b0;
        mem_addr      = fetch_addr;
        mem_data      = '0;
        load_ready    = 1'b0;
        load_busy     = 1'b0;
        load_done     = 1'b0;
        stall         = load_start | (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // A load request wins the port; the coincident fetch is dropped.
                if (load_start) begin
                    ptr_d   = load_base;
                    rem_d   = (load_count > DEPTH_C) ? DEPTH_C : load_count;
                    state_d = (load_count == '0) ? S_DONE : S_LOAD;
                end else if (fetch_req) begin
                    fetch_valid_d = 1'b1;
                    fetch_instr_d = mem_q;
                end
            end
            S_LOAD: begin
                load_busy  = 1'b1;
                load_ready = 1'b1;
                mem_addr   = ptr_q;
                mem_data   = load_data;
                mem_we     = load_valid;
                if (load_valid) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - ONE_C;
                    if (rem_q == ONE_C) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                load_busy = 1'b1;
                load_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            rem_q         <= '0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            rem_q         <= rem_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;

endmodule

// File: tb/tb_im_access_controller.sv
// Scoreboard bench for im_access_controller: a reference memory image predicts
// fetch words, write addresses/data and load_done timing; a monitor pops and checks.
module tb_im_access_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic        fetch_req;
    logic [9:0]  fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        stall;
    logic        load_start;
    logic [9:0]  load_base;
    logic [10:0] load_count;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic [31:0] mem_q;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic init_en;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    logic [31:0] fexp_q[$];
    logic [41:0] wexp_q[$];
    int          dexp_q[$];

    im_access_controller #(
        .ADDR_W(10),
        .DATA_W(32),
        .DEPTH (1024)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .stall      (stall),
        .load_start (load_start),
        .load_base  (load_base),
        .load_count (load_count),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_q      (mem_q)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input int i);
        if (i == 5) return 32'hDEADBEEF;
        if (i == 6) return 32'h12345678;
        return 32'(i * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Memory instance: async read, sync write, preloaded during the first reset cycle.
    assign mem_q = mem[mem_addr];
    always @(posedge CLK) begin
        if (init_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT-presented event must match the head of its expectation queue.
    always @(negedge CLK) begin
        logic [41:0] w;
        logic [31:0] f;
        int          d;
        if (RST === 1'b0) begin
            if (fetch_valid === 1'b1) begin
                if (fexp_q.size() == 0) chk("fetch_unexpected", 1, 0);
                else begin
                    f = fexp_q.pop_front();
                    chk("fetch_instr", fetch_instr, f);
                end
            end
            if (mem_we === 1'b1) begin
                if (wexp_q.size() == 0) chk("write_unexpected", 1, 0);
                else begin
                    w = wexp_q.pop_front();
                    chk("wr_addr", mem_addr, w[41:32]);
                    chk("wr_data", mem_data, w[31:0]);
                end
            end
            if (load_done === 1'b1) begin
                if (dexp_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    d = dexp_q.pop_front();
                    chk("done_cycle", cyc, d);
                end
            end
        end
    end

    task automatic do_fetch(input logic [9:0] a, input bit one_cycle);
        int waited;
        waited     = 0;
        fetch_req  = 1'b1;
        fetch_addr = a;
        fexp_q.push_back(ref_mem[a]);
        do begin
            @(posedge CLK); #1;
            waited++;
        end while (!fetch_valid && waited < 50);
        chk("fetch_timeout", fetch_valid, 1);
        if (one_cycle) chk("fetch_latency", waited, 1);
    endtask

    // Drives one burst. pat bit i gives load_valid for step i (random if pat_len==0,
    // 1 once exhausted). abort_after>=0 asserts RST once that many words are written.
    task automatic run_load(input logic [9:0] base, input logic [10:0] count,
                            input bit with_fetch, input logic [9:0] faddr,
                            input int abort_after, input logic [31:0] pat, input int pat_len);
        int   n;
        int   written;
        int   step;
        logic v;
        logic [9:0]  wa;
        logic [31:0] d;
        n       = (count > 11'd1024) ? 1024 : int'(count);
        written = 0;
        step    = 0;
        load_start = 1'b1;
        load_base  = base;
        load_count = count;
        if (with_fetch) begin
            fetch_req  = 1'b1;
            fetch_addr = faddr;
        end
        #1;
        chk("stall_on_start", stall, 1);
        if (n == 0) dexp_q.push_back(cyc + 1);
        @(posedge CLK); #1;
        load_start = 1'b0;
        while (written < n) begin
            if (abort_after >= 0 && written == abort_after) break;
            if (pat_len == 0) v = 1'($urandom_range(0, 1));
            else if (step < pat_len) v = pat[step];
            else v = 1'b1;
            d          = $urandom;
            load_valid = v;
            load_data  = d;
            #1;
            chk("load_ready", load_ready, 1);
            chk("load_busy", load_busy, 1);
            chk("stall_load", stall, 1);
            chk("fetch_valid_load", fetch_valid, 0);
            chk("mem_we_load", mem_we, v);
            if (v) begin
                wa = 10'((int'(base) + written) % 1024);
                wexp_q.push_back({wa, d});
                ref_mem[wa] = d;
                written++;
                if (written == n) dexp_q.push_back(cyc + 1);
            end
            step++;
            @(posedge CLK); #1;
            load_valid = 1'b0;
        end
        if (abort_after >= 0 && written == abort_after && written < n) begin
            RST = 1'b1;
            @(posedge CLK); #1;
            RST = 1'b0;
            #1;
            chk("abort_busy", load_busy, 0);
            chk("abort_stall", stall, 0);
            chk("abort_ready", load_ready, 0);
            repeat (3) @(posedge CLK);
            #1;
            return;
        end
        #1;
        chk("done_ready", load_ready, 0);
        chk("done_busy", load_busy, 1);
        chk("done_stall", stall, 1);
        chk("done_we", mem_we, 0);
        chk("fetch_valid_done", fetch_valid, 0);
        @(posedge CLK); #1; #1;
        chk("idle_busy", load_busy, 0);
        chk("idle_stall", stall, 0);
        if (with_fetch) begin
            fexp_q.push_back(ref_mem[faddr]);
            @(posedge CLK); #1;
            chk("held_fetch_served", fetch_valid, 1);
            fetch_req = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        RST        = 1'b1;
        init_en    = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_base  = '0;
        load_count = '0;
        load_valid = 1'b0;
        load_data  = '0;
        @(posedge CLK); #1;
        init_en = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_load_busy", load_busy, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fetch_instr", fetch_instr, 0);

        do_fetch(10'd5, 1'b1);
        do_fetch(10'd6, 1'b1);
        fetch_req = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("idle_no_valid", fetch_valid, 0);
        chk("fetch_instr_hold", fetch_instr, 32'h12345678);

        run_load(10'h3FE, 11'd4, 1'b0, '0, -1, 32'hF, 4);
        do_fetch(10'h000, 1'b1);
        do_fetch(10'h3FF, 1'b1);
        fetch_req = 1'b0;

        run_load(10'd10, 11'd3, 1'b1, 10'd11, -1, '0, 0);
        run_load(10'd50, 11'd3, 1'b0, '0, -1, 32'b11001, 5);
        run_load(10'd70, 11'd0, 1'b0, '0, -1, '0, 0);

        run_load(10'd100, 11'd5, 1'b0, '0, 2, 32'b11111, 5);
        for (int a = 100; a < 105; a++) do_fetch(10'(a), 1'b1);
        fetch_req = 1'b0;

        run_load(10'd300, 11'd1500, 1'b0, '0, -1, 32'hFFFFFFFF, 32);
        do_fetch(10'd299, 1'b1);
        do_fetch(10'd300, 1'b1);
        fetch_req = 1'b0;

        for (int r = 0; r < 8; r++) begin
            run_load(10'($urandom), 11'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                     10'($urandom), -1, '0, 0);
            for (int k = 0; k < 3; k++) do_fetch(10'($urandom), 1'b1);
            fetch_req = 1'b0;
            @(posedge CLK); #1;
        end

        repeat (4) @(posedge CLK);
        #1;
        chk("fetch_queue_empty", fexp_q.size(), 0);
        chk("write_queue_empty", wexp_q.size(), 0);
        chk("done_queue_empty", dexp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/im_access_controller.md
Name: im_access_controller

Overview:
- Owns the single port of the 1024x32 instruction memory (async read, sync write on CLK).
- Shares that port between two requesters:
  - the processor fetch stage (reads);
  - a program loader (burst writes from a word stream).
- Sequences loads with an FSM, auto-increments the write address, and stalls fetch while a load is in progress.
- Sits between the fetch unit / boot-load interface and the instruction memory instance.

Parameters:
- ADDR_W, 10, memory address width.
- DATA_W, 32, instruction word width.
- DEPTH, 1024, memory depth in words; equals 2**ADDR_W.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous reset, active-high.
- fetch_req  in  1  fetch stage requests a word this cycle.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_valid  out  1  fetch_instr holds the word for the request accepted last cycle.
- fetch_instr  out  DATA_W  registered fetched instruction.
- stall  out  1  fetch must hold its request; the port is owned by the loader.
- load_start  in  1  one-cycle pulse that begins a load burst.
- load_base  in  ADDR_W  first write address, sampled on load_start.
- load_count  in  ADDR_W+1  number of words to write, sampled on load_start.
- load_valid  in  1  load_data carries a word.
- load_data  in  DATA_W  word to write.
- load_ready  out  1  controller accepts load_data this cycle.
- load_busy  out  1  burst in progress.
- load_done  out  1  one-cycle pulse at burst completion.
- mem_we  out  1  to the memory write enable.
- mem_addr  out  ADDR_W  to the memory address.
- mem_data  out  DATA_W  to the memory write data.
- mem_q  in  DATA_W  from the memory read data (combinational).

Behaviour:

Reset:
- On RST=1 at a posedge, state becomes IDLE.
- fetch_valid, fetch_instr, load_done, the write pointer and the remaining-word counter all clear to 0.
- Memory contents are not touched.

FSM states: IDLE, LOAD, DONE.

IDLE:
- Default outputs: mem_we=0, mem_addr=fetch_addr, mem_data=0.
- If fetch_req=1 and load_start=0:
  - fetch_instr <= mem_q and fetch_valid <= 1 at the next posedge.
  - Latency is 1 cycle; back-to-back fetches give one word per cycle.
- Otherwise fetch_valid <= 0.
- load_start=1 has priority over fetch_req in the same cycle:
  - That fetch is not served; fetch_valid <= 0.
  - ptr <= load_base.
  - rem <= min(load_count, DEPTH).
  - Next state is LOAD, or DONE if load_count=0.

LOAD:
- Outputs: load_busy=1, load_ready=1, fetch_valid=0.
- On a cycle with load_valid=1:
  - mem_we=1, mem_addr=ptr, mem_data=load_data.
  - ptr <= ptr+1, wrapping from DEPTH-1 to 0.
  - rem <= rem-1.
  - If rem=1, next state is DONE.
- load_valid=0 stalls the burst indefinitely with no write; the pointer holds.
- While in LOAD, mem_addr=ptr and mem_we=load_valid.
- load_start in LOAD is ignored; there is no restart.

DONE:
- One cycle: load_done=1, load_busy=1, load_ready=0, mem_we=0.
- Next state is IDLE.

stall:
- Combinational: stall = (state!=IDLE) | load_start.
- Fetch requests seen while stall=1 are dropped; the requester must hold fetch_req until it receives fetch_valid.

Fetch results:
- fetch_instr holds its last value when fetch_valid=0.
- A fetch whose address equals a location written in that same cycle cannot occur, because loads and fetches are exclusive.

Reset mid-burst:
- Aborts immediately to IDLE.
- Words already written stay in memory.
- No load_done is generated.

Width rules:
- ptr is ADDR_W bits and wraps modulo DEPTH.
- rem is ADDR_W+1 bits.
- load_count > DEPTH is clamped to DEPTH.

Test Plan:
- Reset, then check outputs: fetch_valid=0, load_busy=0, load_done=0, mem_we=0, stall=0, fetch_instr=0.
- Preload the memory model with mem[5]=0xDEADBEEF and mem[6]=0x12345678; fetch_req=1 with addr 5 then 6 on consecutive cycles -> fetch_valid=1 one cycle later with fetch_instr 0xDEADBEEF, then 0x12345678.
- load_start with base=0x3FE, count=4 and continuous load_valid with data A,B,C,D -> writes land at 0x3FE, 0x3FF, 0x000, 0x001; load_done pulses exactly 1 cycle after the 4th write; stall=1 from the load_start cycle through DONE.
- load_start and fetch_req asserted in the same cycle -> no fetch_valid, LOAD entered; fetch held high gets served on the first IDLE cycle after DONE.
- load_valid toggled 1,0,0,1,1 during count=3 -> exactly 3 writes at consecutive addresses, no write on idle cycles; load_count=0 -> LOAD skipped, load_done 1 cycle after start, no writes.
- RST asserted after 2 of 5 words -> state IDLE next cycle, load_done never pulses; readback shows the first 2 words written and the others unchanged.
